// File: rtl/pwm_update_ctrl_if.sv
// Configuration write channel into pwm_update_ctrl: valid/ready handshake plus one full PWM config.
// Latency: none, this is wiring only.
// Backpressure: the slave holds cfg_ready low while a scheduled update is still pending.
// Ports: master drives cfg_valid and all cfg_* data; slave drives cfg_ready.
interface pwm_update_ctrl_if #(
    parameter int WIDTH      = 16,
    parameter int SKIP_WIDTH = 4
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [WIDTH-1:0]      cfg_period;
    logic [WIDTH-1:0]      cfg_init_carr;
    logic [WIDTH-1:0]      cfg_compare_1;
    logic [WIDTH-1:0]      cfg_compare_2;
    logic [WIDTH-1:0]      cfg_compare_3;
    logic [WIDTH-1:0]      cfg_compare_4;
    logic [1:0]            cfg_upd_mode;
    logic [SKIP_WIDTH-1:0] cfg_upd_skip;

    modport master (
        output cfg_valid, cfg_period, cfg_init_carr,
               cfg_compare_1, cfg_compare_2, cfg_compare_3, cfg_compare_4,
               cfg_upd_mode, cfg_upd_skip,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_init_carr,
               cfg_compare_1, cfg_compare_2, cfg_compare_3, cfg_compare_4,
               cfg_upd_mode, cfg_upd_skip,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_update_ctrl.sv
// Shadow-register update scheduler: commits a full PWM config atomically at a chosen carrier event.
// Latency: immediate commit visible 1 cycle after acceptance; scheduled commit 1 cycle after the qualifying event.
// Backpressure: cfg_ready drops while a scheduled config waits in the shadow; immediate writes can stream every cycle.
// Ports: clk/reset (sync, active-low); cfg (slave modport, config handshake); pwm_enable, evt_zero, evt_max
// from the PWM; period/init_carr/compare_1..4 active values; upd_pending, upd_pulse, upd_count status.
module pwm_update_ctrl #(
    parameter int WIDTH         = 16,
    parameter int SKIP_WIDTH    = 4,
    parameter int RST_PERIOD    = 2000,
    parameter int RST_INIT_CARR = 0,
    parameter int RST_COMPARE   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    pwm_update_ctrl_if.slave       cfg,
    input  logic                   pwm_enable,
    input  logic                   evt_zero,
    input  logic                   evt_max,
    output logic [WIDTH-1:0]       period,
    output logic [WIDTH-1:0]       init_carr,
    output logic [WIDTH-1:0]       compare_1,
    output logic [WIDTH-1:0]       compare_2,
    output logic [WIDTH-1:0]       compare_3,
    output logic [WIDTH-1:0]       compare_4,
    output logic                   upd_pending,
    output logic                   upd_pulse,
    output logic [15:0]            upd_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] period;
        logic [WIDTH-1:0] init_carr;
        logic [WIDTH-1:0] compare_1;
        logic [WIDTH-1:0] compare_2;
        logic [WIDTH-1:0] compare_3;
        logic [WIDTH-1:0] compare_4;
    } cfg_t;

    logic [0:0]            state;
    cfg_t                  active;
    cfg_t                  shadow;
    cfg_t                  cfg_in;
    cfg_t                  rst_cfg;
    logic [1:0]            mode_q;
    logic [SKIP_WIDTH-1:0] skip_cnt;
    logic                  qual_evt;

    assign cfg_in = {cfg.cfg_period, cfg.cfg_init_carr, cfg.cfg_compare_1,
                     cfg.cfg_compare_2, cfg.cfg_compare_3, cfg.cfg_compare_4};

    assign rst_cfg = {WIDTH'(RST_PERIOD), WIDTH'(RST_INIT_CARR), WIDTH'(RST_COMPARE),
                      WIDTH'(RST_COMPARE), WIDTH'(RST_COMPARE), WIDTH'(RST_COMPARE)};

    // Mode bit 0 selects zero events, bit 1 selects max events. Both firing in
    // the same cycle collapse into a single qualifying event through the OR.
    assign qual_evt = (mode_q[0] & evt_zero) | (mode_q[1] & evt_max);

    // Ready is gated by reset so the writer sees 0 throughout reset, and 1 as
    // soon as reset releases (state is already IDLE by then).
    assign cfg.cfg_ready = reset & (state == IDLE);
    assign upd_pending   = (state == WAIT);

    assign period    = active.period;
    assign init_carr = active.init_carr;
    assign compare_1 = active.compare_1;
    assign compare_2 = active.compare_2;
    assign compare_3 = active.compare_3;
    assign compare_4 = active.compare_4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            active    <= rst_cfg;
            shadow    <= '0;
            mode_q    <= 2'b00;
            skip_cnt  <= '0;
            upd_pulse <= 1'b0;
            upd_count <= 16'd0;
        end else begin
            upd_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg.cfg_valid) begin
                        // A stopped carrier produces no events, so waiting would
                        // never finish; commit straight away instead.
                        if (cfg.cfg_upd_mode == 2'b00 || !pwm_enable) begin
                            active    <= cfg_in;
                            upd_pulse <= 1'b1;
                            upd_count <= upd_count + 16'd1;
                        end else begin
                            shadow   <= cfg_in;
                            mode_q   <= cfg.cfg_upd_mode;
                            skip_cnt <= cfg.cfg_upd_skip;
                            state    <= WAIT;
                        end
                    end
                end
                default: begin
                    if (!pwm_enable || (qual_evt && skip_cnt == '0)) begin
                        active    <= shadow;
                        upd_pulse <= 1'b1;
                        upd_count <= upd_count + 16'd1;
                        state     <= IDLE;
                    end else if (qual_evt) begin
                        skip_cnt <= skip_cnt - SKIP_WIDTH'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Testbench for pwm_update_ctrl: directed cycle table, randomized run against a reference model,
// and an upd_count wrap sequence.
module tb_pwm_update_ctrl;
    logic        clk;
    logic        reset;
    logic        pwm_enable;
    logic        evt_zero;
    logic        evt_max;
    logic [15:0] period, init_carr, compare_1, compare_2, compare_3, compare_4;
    logic        upd_pending, upd_pulse;
    logic [15:0] upd_count;

    int n_checks = 0;
    int n_errors = 0;

    pwm_update_ctrl_if #(.WIDTH(16), .SKIP_WIDTH(4)) cfg_if ();

    pwm_update_ctrl #(
        .WIDTH(16), .SKIP_WIDTH(4), .RST_PERIOD(2000), .RST_INIT_CARR(0), .RST_COMPARE(0)
    ) dut (
        .clk(clk), .reset(reset), .cfg(cfg_if), .pwm_enable(pwm_enable),
        .evt_zero(evt_zero), .evt_max(evt_max),
        .period(period), .init_carr(init_carr),
        .compare_1(compare_1), .compare_2(compare_2), .compare_3(compare_3), .compare_4(compare_4),
        .upd_pending(upd_pending), .upd_pulse(upd_pulse), .upd_count(upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] per, ic, c1, c2, c3, c4;
    } cfg_t;

    cfg_t m_act, m_shadow;
    bit   m_pend;
    bit   m_pulse;
    int   m_events_needed;
    int   m_mode;
    int   m_count;

    function automatic cfg_t cur_cfg();
        cfg_t c;
        c.per = cfg_if.cfg_period;    c.ic = cfg_if.cfg_init_carr;
        c.c1  = cfg_if.cfg_compare_1; c.c2 = cfg_if.cfg_compare_2;
        c.c3  = cfg_if.cfg_compare_3; c.c4 = cfg_if.cfg_compare_4;
        return c;
    endfunction

    task automatic model_commit(input cfg_t c);
        m_act   = c;
        m_count = (m_count + 1) % 65536;
        m_pulse = 1'b1;
    endtask

    // Evaluates the clock edge about to happen from the inputs currently applied.
    task automatic model_step();
        bit ev;
        if (!reset) begin
            m_act   = '{per: 16'd2000, ic: 16'd0, c1: 16'd0, c2: 16'd0, c3: 16'd0, c4: 16'd0};
            m_pend  = 1'b0;
            m_pulse = 1'b0;
            m_count = 0;
        end else begin
            m_pulse = 1'b0;
            if (!m_pend) begin
                if (cfg_if.cfg_valid) begin
                    if (cfg_if.cfg_upd_mode == 2'd0 || !pwm_enable) begin
                        model_commit(cur_cfg());
                    end else begin
                        m_pend          = 1'b1;
                        m_shadow        = cur_cfg();
                        m_mode          = int'(cfg_if.cfg_upd_mode);
                        m_events_needed = int'(cfg_if.cfg_upd_skip) + 1;
                    end
                end
            end else begin
                case (m_mode)
                    1:       ev = evt_zero;
                    2:       ev = evt_max;
                    default: ev = evt_zero || evt_max;
                endcase
                if (!pwm_enable) begin
                    model_commit(m_shadow);
                    m_pend = 1'b0;
                end else if (ev) begin
                    m_events_needed--;
                    if (m_events_needed == 0) begin
                        model_commit(m_shadow);
                        m_pend = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    // One clock: update the model, take the edge, compare every output 1 time unit later.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("period",      32'(period),      32'(m_act.per));
        chk("init_carr",   32'(init_carr),   32'(m_act.ic));
        chk("compare_1",   32'(compare_1),   32'(m_act.c1));
        chk("compare_2",   32'(compare_2),   32'(m_act.c2));
        chk("compare_3",   32'(compare_3),   32'(m_act.c3));
        chk("compare_4",   32'(compare_4),   32'(m_act.c4));
        chk("upd_pending", 32'(upd_pending), 32'(m_pend));
        chk("upd_pulse",   32'(upd_pulse),   32'(m_pulse));
        chk("upd_count",   32'(upd_count),   32'(m_count));
        chk("cfg_ready",   32'(cfg_if.cfg_ready), 32'(reset && !m_pend));
    endtask

    task automatic drive(input bit rst, input bit vld, input bit en, input bit ez, input bit em,
                         input logic [1:0] mode, input logic [3:0] skip,
                         input logic [15:0] per, input logic [15:0] cmp);
        reset                = rst;
        cfg_if.cfg_valid     = vld;
        pwm_enable           = en;
        evt_zero             = ez;
        evt_max              = em;
        cfg_if.cfg_upd_mode  = mode;
        cfg_if.cfg_upd_skip  = skip;
        cfg_if.cfg_period    = per;
        cfg_if.cfg_init_carr = cmp ^ 16'h5a5a;
        cfg_if.cfg_compare_1 = cmp;
        cfg_if.cfg_compare_2 = cmp + 16'd1;
        cfg_if.cfg_compare_3 = cmp + 16'd2;
        cfg_if.cfg_compare_4 = cmp + 16'd3;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit rst, vld, en, ez, em;
        logic [1:0]  mode;
        logic [3:0]  skip;
        logic [15:0] per, cmp;
        logic [15:0] e_per, e_cmp;
        bit e_pend, e_pulse;
        logic [15:0] e_cnt;
        bit e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit vld, bit en, bit ez, bit em, logic [1:0] mode,
                                logic [3:0] skip, logic [15:0] per, logic [15:0] cmp,
                                logic [15:0] e_per, logic [15:0] e_cmp, bit e_pend, bit e_pulse,
                                logic [15:0] e_cnt, bit e_rdy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.en = en; v.ez = ez; v.em = em; v.mode = mode; v.skip = skip;
        v.per = per; v.cmp = cmp; v.e_per = e_per; v.e_cmp = e_cmp; v.e_pend = e_pend;
        v.e_pulse = e_pulse; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
        return v;
    endfunction

    initial begin
        //                 rst vld en ez em mode skip per   cmp    e_per e_cmp pend pulse cnt rdy
        // reset
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd0, 4'd0, 16'd0,    16'd0,   2000, 0,   0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd0, 4'd0, 16'd5,    16'd5,   2000, 0,   0, 0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd0, 4'd0, 16'd0,    16'd0,   2000, 0,   0, 0, 0,  1));
        // immediate writes, back to back
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd0, 4'd0, 16'd1500, 16'd667, 1500, 667, 0, 1, 1,  1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd0, 4'd0, 16'd1600, 16'd700, 1600, 700, 0, 1, 2,  1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd0, 4'd0, 16'd0,    16'd0,   1600, 700, 0, 0, 2,  1));
        // zero-aligned: max ignored, zero commits
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd1, 4'd0, 16'd1500, 16'd500, 1600, 700, 1, 0, 2,  0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 2'd1, 4'd0, 16'd0,    16'd0,   1600, 700, 1, 0, 2,  0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd1, 4'd0, 16'd0,    16'd0,   1600, 700, 1, 0, 2,  0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 2'd1, 4'd0, 16'd0,    16'd0,   1500, 500, 0, 1, 3,  1));
        // either mode, skip 2, separate events
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd3, 4'd2, 16'd1200, 16'd300, 1500, 500, 1, 0, 3,  0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 2'd3, 4'd0, 16'd0,    16'd0,   1500, 500, 1, 0, 3,  0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 2'd3, 4'd0, 16'd0,    16'd0,   1500, 500, 1, 0, 3,  0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 2'd3, 4'd0, 16'd0,    16'd0,   1200, 300, 0, 1, 4,  1));
        // either mode, skip 2, simultaneous events count once each cycle
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd3, 4'd2, 16'd1100, 16'd200, 1200, 300, 1, 0, 4,  0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 2'd3, 4'd0, 16'd0,    16'd0,   1200, 300, 1, 0, 4,  0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 2'd3, 4'd0, 16'd0,    16'd0,   1200, 300, 1, 0, 4,  0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 2'd3, 4'd0, 16'd0,    16'd0,   1100, 200, 0, 1, 5,  1));
        // event in the acceptance cycle is not counted
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'd1, 4'd0, 16'd1000, 16'd100, 1100, 200, 1, 0, 5,  0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 2'd1, 4'd0, 16'd0,    16'd0,   1000, 100, 0, 1, 6,  1));
        // carrier stopped: forces commit in WAIT, immediate commit in IDLE
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd1, 4'd3, 16'd900,  16'd90,  1000, 100, 1, 0, 6,  0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2'd1, 4'd0, 16'd0,    16'd0,   900,  90,  0, 1, 7,  1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 2'd2, 4'd0, 16'd800,  16'd80,  800,  80,  0, 1, 8,  1));
        // backpressure: held write taken in first IDLE cycle
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd2, 4'd0, 16'd700,  16'd70,  800,  80,  1, 0, 8,  0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd2, 4'd0, 16'd600,  16'd60,  800,  80,  1, 0, 8,  0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 2'd2, 4'd0, 16'd600,  16'd60,  700,  70,  0, 1, 9,  1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd2, 4'd0, 16'd600,  16'd60,  700,  70,  1, 0, 9,  0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 2'd2, 4'd0, 16'd0,    16'd0,   600,  60,  0, 1, 10, 1));
        // reset while waiting discards the pending config
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'd1, 4'd0, 16'd1000, 16'd10,  600,  60,  1, 0, 10, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd1, 4'd0, 16'd0,    16'd0,   2000, 0,   0, 0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 2'd1, 4'd0, 16'd0,    16'd0,   2000, 0,   0, 0, 0,  1));

        drive(0, 0, 1, 0, 0, 2'd0, 4'd0, 16'd0, 16'd0);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            string tag;
            v = vecs[i];
            drive(v.rst, v.vld, v.en, v.ez, v.em, v.mode, v.skip, v.per, v.cmp);
            step();
            tag = $sformatf("row%0d", i);
            chk({tag, ".period"},    32'(period),            32'(v.e_per));
            chk({tag, ".compare_1"}, 32'(compare_1),         32'(v.e_cmp));
            chk({tag, ".pending"},   32'(upd_pending),       32'(v.e_pend));
            chk({tag, ".pulse"},     32'(upd_pulse),         32'(v.e_pulse));
            chk({tag, ".count"},     32'(upd_count),         32'(v.e_cnt));
            chk({tag, ".ready"},     32'(cfg_if.cfg_ready),  32'(v.e_rdy));
        end

        // ---------------- randomized run ----------------
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom));
            step();
        end

        // ---------------- upd_count wrap ----------------
        drive(0, 0, 1, 0, 0, 2'd0, 4'd0, 16'd0, 16'd0);
        step();
        for (int c = 0; c < 65535; c++) begin
            drive(1, 1, 1, 0, 0, 2'd0, 4'd0, 16'($urandom), 16'($urandom));
            step();
        end
        chk("wrap.count_ffff", 32'(upd_count), 32'h0000_ffff);
        drive(1, 1, 1, 0, 0, 2'd0, 4'd0, 16'd1234, 16'd42);
        step();
        chk("wrap.count_zero", 32'(upd_count), 32'd0);
        chk("wrap.pulse",      32'(upd_pulse), 32'd1);
        chk("wrap.period",     32'(period),    32'd1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
